// File: rtl/register_array_pkg.sv
// register_array_pkg: shared sizes and types for the register file.
// Imported by the register file top and its storage cell.
package register_array_pkg;

    localparam int XLEN       = 32;
    localparam int SELECT_LEN = 5;
    localparam int NUM_REGS   = 2 ** SELECT_LEN;

    typedef logic [SELECT_LEN-1:0] reg_select_t;
    typedef logic [XLEN-1:0]       word_t;

endpackage : register_array_pkg

// File: rtl/register_cell.sv
// register_cell: one word of storage with async clear, load enable
// and two independent tri-state read ports.
module register_cell
    import register_array_pkg::*;
#(
    parameter int WIDTH = register_array_pkg::XLEN
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             oe_a_i,
    input  logic             oe_b_i,
    output tri   [WIDTH-1:0] a_o,
    output tri   [WIDTH-1:0] b_o
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next value: take the write data only when this cell is selected.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = data_i;
        end
    end

    // Storage, cleared immediately when reset is asserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign a_o = oe_a_i ? value_q : {WIDTH{1'bz}};
    assign b_o = oe_b_i ? value_q : {WIDTH{1'bz}};

endmodule : register_cell

// File: rtl/register_array.sv
// register_array: 31 stored registers plus a storage-less index 0,
// one synchronous write port and two tri-state combinational reads.
module register_array
    import register_array_pkg::*;
#(
    parameter int XLEN       = register_array_pkg::XLEN,
    parameter int SELECT_LEN = register_array_pkg::SELECT_LEN
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SELECT_LEN-1:0] store,
    input  logic [SELECT_LEN-1:0] enable_a,
    input  logic [SELECT_LEN-1:0] enable_b,
    input  logic [XLEN-1:0]       store_value,
    output tri   [XLEN-1:0]       a_bus,
    output tri   [XLEN-1:0]       b_bus
);

    localparam int NREGS = 2 ** SELECT_LEN;

    // Index 0 has no cell, so the decoded vectors start at bit 1.
    logic [NREGS-1:1] load_oh;
    logic [NREGS-1:1] oe_a_oh;
    logic [NREGS-1:1] oe_b_oh;

    // One-hot decode of the three selectors; selector 0 enables nothing.
    always_comb begin
        load_oh = '0;
        oe_a_oh = '0;
        oe_b_oh = '0;
        for (int i = 1; i < NREGS; i++) begin
            load_oh[i] = (store    == SELECT_LEN'(i));
            oe_a_oh[i] = (enable_a == SELECT_LEN'(i));
            oe_b_oh[i] = (enable_b == SELECT_LEN'(i));
        end
    end

    for (genvar g = 1; g < NREGS; g++) begin : g_cell
        register_cell #(
            .WIDTH (XLEN)
        ) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .load_i  (load_oh[g]),
            .data_i  (store_value),
            .oe_a_i  (oe_a_oh[g]),
            .oe_b_i  (oe_b_oh[g]),
            .a_o     (a_bus),
            .b_o     (b_bus)
        );
    end

endmodule : register_array

// File: tb/tb_register_array.sv
// tb_register_array: directed stimulus with a queued scoreboard;
// a separate monitor pops expectations and compares the buses.
module tb_register_array;

    typedef struct {
        string       name;
        bit [31:0]   a;
        bit          az;
        bit [31:0]   b;
        bit          bz;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [4:0]  store;
    logic [4:0]  enable_a;
    logic [4:0]  enable_b;
    logic [31:0] store_value;
    wire  [31:0] a_bus;
    wire  [31:0] b_bus;

    exp_t      exp_q[$];
    event      sample_ev;
    int        checks;
    int        errors;
    bit [31:0] model [32];

    register_array dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .store       (store),
        .enable_a    (enable_a),
        .enable_b    (enable_b),
        .store_value (store_value),
        .a_bus       (a_bus),
        .b_bus       (b_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one expectation and let the monitor sample it.
    task automatic expect_bus(input string nm,
                              input bit [31:0] ea, input bit za,
                              input bit [31:0] eb, input bit zb);
        exp_t e;
        e.name = nm;
        e.a    = ea;
        e.az   = za;
        e.b    = eb;
        e.bz   = zb;
        exp_q.push_back(e);
        #1;
        ->sample_ev;
        #1;
    endtask

    // Write one register on the next rising edge.
    task automatic wr(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        store       = idx;
        store_value = val;
        @(posedge clk);
        if (reset_n && idx != 5'd0) model[idx] = val;
        #1;
        store = 5'd0;
    endtask

    // Read every stored register through both buses.
    task automatic sweep(input string nm);
        for (int i = 1; i < 32; i++) begin
            enable_a = 5'(i);
            enable_b = 5'(32 - i);
            expect_bus(nm, model[i], 1'b0, model[32-i], 1'b0);
        end
    endtask

    // Monitor: compare buses against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (e.az) begin
                    if (a_bus !== 32'hzzzzzzzz) begin
                        errors++;
                        $display("FAIL %s a_bus: got %h want zzzzzzzz",
                                 e.name, a_bus);
                    end
                end else if (a_bus !== e.a) begin
                    errors++;
                    $display("FAIL %s a_bus: got %h want %h",
                             e.name, a_bus, e.a);
                end
                checks++;
                if (e.bz) begin
                    if (b_bus !== 32'hzzzzzzzz) begin
                        errors++;
                        $display("FAIL %s b_bus: got %h want zzzzzzzz",
                                 e.name, b_bus);
                    end
                end else if (b_bus !== e.b) begin
                    errors++;
                    $display("FAIL %s b_bus: got %h want %h",
                             e.name, b_bus, e.b);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        store       = 5'd0;
        enable_a    = 5'd1;
        enable_b    = 5'd31;
        store_value = 32'h0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset: selected regs read 0, selector 0 floats.
        expect_bus("reset_sel", 32'h0, 1'b0, 32'h0, 1'b0);
        enable_a = 5'd0;
        enable_b = 5'd0;
        expect_bus("reset_z", 32'h0, 1'b1, 32'h0, 1'b1);
        // Writes suppressed during reset.
        wr(5'd4, 32'hCAFEF00D);
        enable_a = 5'd4;
        expect_bus("reset_nowrite", 32'h0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;

        // Write then read.
        wr(5'd5, 32'hDEADBEEF);
        enable_a = 5'd5;
        enable_b = 5'd0;
        expect_bus("wr_rd", 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);

        // Store to index 0 changes nothing.
        wr(5'd0, 32'h12345678);
        enable_a = 5'd0;
        enable_b = 5'd5;
        expect_bus("store0_z", 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
        sweep("store0_sweep");

        // Same-cycle read/write of register 3.
        wr(5'd3, 32'h00000011);
        @(negedge clk);
        store       = 5'd3;
        store_value = 32'h00000022;
        enable_a    = 5'd3;
        enable_b    = 5'd0;
        expect_bus("rw_before", 32'h00000011, 1'b0, 32'h0, 1'b1);
        @(posedge clk);
        model[3] = 32'h00000022;
        expect_bus("rw_after", 32'h00000022, 1'b0, 32'h0, 1'b1);
        store = 5'd0;

        // Dual read, then both buses on the same register.
        wr(5'd1, 32'hAAAAAAAA);
        wr(5'd2, 32'h55555555);
        enable_a = 5'd2;
        enable_b = 5'd1;
        expect_bus("dual", 32'h55555555, 1'b0, 32'hAAAAAAAA, 1'b0);
        enable_b = 5'd2;
        expect_bus("same_sel", 32'h55555555, 1'b0, 32'h55555555, 1'b0);

        // Reset asserted across a write edge wins.
        wr(5'd7, 32'h77777777);
        @(negedge clk);
        store       = 5'd7;
        store_value = 32'h99999999;
        #3;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        store = 5'd0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(negedge clk);
        reset_n  = 1'b1;
        enable_a = 5'd7;
        enable_b = 5'd0;
        expect_bus("rst_wins", 32'h0, 1'b0, 32'h0, 1'b1);

        // Fill all, then pulse reset between edges.
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'h10000000 + 32'(i) * 32'h01010101);
        end
        sweep("fill");
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        enable_a = 5'd17;
        enable_b = 5'd31;
        expect_bus("pulse_during", 32'h0, 1'b0, 32'h0, 1'b0);
        reset_n = 1'b1;
        sweep("pulse_after");

        // Drain the scoreboard with a bound.
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule : tb_register_array
